mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MIPS load/store unit of the MEM stage: sits between the EX/MEM pipeline outputs and the MEM/WB register.
//  Decodes the memory op, drives a req/ack data-memory bus with big-endian byte lanes and stalls the pipeline
//  until the access completes. Sign/zero-extends load data and forwards the GPR/hi/lo writeback fields.
//  Flags misaligned accesses (AdEL/AdES) instead of issuing them.
// PARAMETERS
//  DW     32  data/register width (REGBUS)
//  RAW    5   register address width (REGADDRBUS)
//  MAW    32  data-memory byte address width
// PORTS
//  clk          in   1    clock
//  rst          in   1    asynchronous, active-high reset
//  i_memop      in   4    0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW; 9-15 treated as NONE
//  i_addr       in   MAW  effective byte address (ALU result for loads/stores)
//  i_sdata      in   DW   store data (rt)
//  i_waddr      in   RAW  GPR dest
//  i_we         in   1    GPR write enable
//  i_wdata      in   DW   GPR write data for non-load ops
//  i_whi/i_wlo  in   1    hi/lo write enables
//  i_hi/i_lo    in   DW   hi/lo write data
//  o_mem_waddr  out  RAW  to MEM/WB register
//  o_mem_we     out  1    to MEM/WB register
//  o_mem_wdata  out  DW   to MEM/WB register (load result or i_wdata)
//  o_mem_whi/o_mem_wlo/o_mem_hi/o_mem_lo  out  1/1/DW/DW  hi/lo pass-through
//  o_stall_req  out  1    hold PC..EX/MEM stable, MEM/WB captures nothing useful while 1
//  o_dm_req     out  1    bus request, registered
//  o_dm_we      out  1    1=store
//  o_dm_addr    out  MAW  word address, bits[1:0]=0
//  o_dm_be      out  4    byte enables, be[3]=bits31:24=byte offset 0 (big-endian)
//  o_dm_wdata   out  DW   store data replicated to lanes
//  i_dm_ack     in   1    access done; rdata valid same cycle
//  i_dm_rdata   in   DW   read data
//  o_adel/o_ades out 1    misaligned load/store flag
//  o_badaddr    out  MAW  offending address (valid with o_adel/o_ades)
// BEHAVIOUR
//  Reset: FSM->IDLE; every output 0 while rst=1 and in first cycle after release (no load pending).
//  FSM IDLE/BUS/DONE. Inputs held stable by upstream while o_stall_req=1.
//  IDLE: op NONE -> outputs = combinational pass-through of i_* fields, stall 0, stay IDLE.
//    aligned mem op -> o_stall_req=1 (comb), latch addr/be/wdata/we/offset/op, -> BUS.
//    misaligned (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0) -> no bus access, stall 0,
//      o_mem_we=0, o_adel (loads) or o_ades (stores)=1 this cycle, o_badaddr=i_addr.
//  BUS: o_dm_req=1 held with constant addr/we/be/wdata until i_dm_ack; o_stall_req=1.
//    on ack: capture i_dm_rdata -> DONE; o_dm_req low in DONE. Ack outside BUS ignored.
//  DONE: o_stall_req=0; o_mem_wdata=extended load data (stores: o_mem_we=0); other fields pass-through;
//    -> IDLE unconditionally.
//  Min latency, zero-wait ack: stall in 2 cycles (IDLE,BUS), result presented in 3rd (DONE).
//  Byte lanes: SB be=1000>>addr[1:0], data={4{sdata[7:0]}}; SH be=1100 (off 0) / 0011 (off 2),
//    data={2{sdata[15:0]}}; SW be=1111. Loads be per same rule, ignored by slave on reads.
//  Extension: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW full word.
//  Stores: o_mem_we forced 0 regardless of i_we. hi/lo fields always pass through, never gated.
//  Reset mid-BUS: o_dm_req drops asynchronously, request abandoned, FSM IDLE; slave must tolerate.
// TESTING
//  ALU op, i_we=1 waddr=3 wdata=0x1234 -> same cycle o_mem_we=1 waddr=3 wdata=0x1234, stall 0, req 0.
//  LB addr=0x1001, ack immediate, rdata=0x11F23344 -> be=0100, 2 stall cycles, o_mem_wdata=0xFFFFFFF2.
//  LHU addr=0x2002, ack after 3 BUS cycles, rdata=0xAAAA8001 -> stall 4 cycles, wdata=0x00008001.
//  SH addr=0x10 sdata=0xCAFEBEEF -> o_dm_we=1 be=1100 wdata=0xBEEFBEEF, o_mem_we=0 in DONE.
//  LW addr=0x3 -> no req, o_adel=1 badaddr=0x3, o_mem_we=0, stall 0; SW addr=0x6 -> o_ades=1.
//  rst asserted in BUS -> o_dm_req=0 immediately; post-release ALU op passes, late ack ignored.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage load/store unit for a 5-stage MIPS pipeline.
// Sits between the EX/MEM outputs and the MEM/WB register. Issues word-aligned
// req/ack data-memory accesses with big-endian byte enables, stalls the pipeline
// until the access completes, extends load data, and flags misaligned accesses.
//
// Ports:
//   clk, rst (async, active-high)
//   i_memop, i_addr, i_sdata      : memory op, effective byte address, store data
//   i_waddr/i_we/i_wdata          : GPR writeback fields from EX/MEM
//   i_whi/i_wlo/i_hi/i_lo         : hi/lo writeback fields (always passed through)
//   o_mem_*                       : writeback fields toward MEM/WB
//   o_stall_req                   : hold the pipeline while a bus access is in flight
//   o_dm_req/we/addr/be/wdata     : data-memory bus request (be[3] = byte offset 0)
//   i_dm_ack, i_dm_rdata          : bus completion, read data valid with ack
//   o_adel/o_ades/o_badaddr       : misaligned load/store flag and faulting address
//
// Byte lanes and the load extractor assume DW = 32.
module mem_access #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RAW = 5,
  parameter int unsigned MAW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     i_memop,
  input  logic [MAW-1:0] i_addr,
  input  logic [DW-1:0]  i_sdata,
  input  logic [RAW-1:0] i_waddr,
  input  logic           i_we,
  input  logic [DW-1:0]  i_wdata,
  input  logic           i_whi,
  input  logic           i_wlo,
  input  logic [DW-1:0]  i_hi,
  input  logic [DW-1:0]  i_lo,
  output logic [RAW-1:0] o_mem_waddr,
  output logic           o_mem_we,
  output logic [DW-1:0]  o_mem_wdata,
  output logic           o_mem_whi,
  output logic           o_mem_wlo,
  output logic [DW-1:0]  o_mem_hi,
  output logic [DW-1:0]  o_mem_lo,
  output logic           o_stall_req,
  output logic           o_dm_req,
  output logic           o_dm_we,
  output logic [MAW-1:0] o_dm_addr,
  output logic [3:0]     o_dm_be,
  output logic [DW-1:0]  o_dm_wdata,
  input  logic           i_dm_ack,
  input  logic [DW-1:0]  i_dm_rdata,
  output logic           o_adel,
  output logic           o_ades,
  output logic [MAW-1:0] o_badaddr
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [3:0]     op_q;
  logic [1:0]     off_q;
  logic [MAW-1:0] addr_q;
  logic [3:0]     be_q;
  logic [DW-1:0]  sdata_q;
  logic           store_q;
  logic [DW-1:0]  rdata_q;

  logic           is_load, is_store, misaligned, start;
  logic [3:0]     be_d;
  logic [DW-1:0]  sdata_d;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [DW-1:0]  ld_data;

  // Decode the incoming op and build the bus lanes for it.
  always_comb begin
    is_load    = (i_memop >= OpLb) && (i_memop <= OpLw);
    is_store   = (i_memop >= OpSb) && (i_memop <= OpSw);
    misaligned = 1'b0;
    be_d       = 4'b1111;
    sdata_d    = i_sdata;
    unique case (i_memop)
      OpLb, OpLbu, OpSb: begin
        be_d    = 4'b1000 >> i_addr[1:0];
        sdata_d = {4{i_sdata[7:0]}};
      end
      OpLh, OpLhu, OpSh: begin
        misaligned = i_addr[0];
        be_d       = i_addr[1] ? 4'b0011 : 4'b1100;
        sdata_d    = {2{i_sdata[15:0]}};
      end
      OpLw, OpSw: misaligned = |i_addr[1:0];
      default: ;
    endcase
    start = (is_load || is_store) && !misaligned;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StBus;
      StBus:   if (i_dm_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      sdata_q <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        op_q    <= i_memop;
        off_q   <= i_addr[1:0];
        addr_q  <= {i_addr[MAW-1:2], 2'b00};
        be_q    <= be_d;
        sdata_q <= sdata_d;
        store_q <= is_store;
      end
      if (state_q == StBus && i_dm_ack) rdata_q <= i_dm_rdata;
    end
  end

  // Big-endian lane select: offset 0 lives in bits 31:24.
  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = rdata_q[31:24];
      2'd1:    ld_byte = rdata_q[23:16];
      2'd2:    ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    unique case (op_q)
      OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   ld_data = {24'd0, ld_byte};
      OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
      OpLhu:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

  // Writeback/exception outputs; everything is forced low while reset is held.
  always_comb begin
    o_mem_waddr = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_mem_whi   = 1'b0;
    o_mem_wlo   = 1'b0;
    o_mem_hi    = '0;
    o_mem_lo    = '0;
    o_stall_req = 1'b0;
    o_adel      = 1'b0;
    o_ades      = 1'b0;
    o_badaddr   = '0;
    if (!rst) begin
      o_mem_waddr = i_waddr;
      o_mem_we    = i_we;
      o_mem_wdata = i_wdata;
      o_mem_whi   = i_whi;
      o_mem_wlo   = i_wlo;
      o_mem_hi    = i_hi;
      o_mem_lo    = i_lo;
      unique case (state_q)
        StIdle: begin
          if (is_load || is_store) o_mem_we = 1'b0;
          if (start) o_stall_req = 1'b1;
          if (misaligned) begin
            o_adel    = is_load;
            o_ades    = is_store;
            o_badaddr = i_addr;
          end
        end
        StBus: begin
          o_stall_req = 1'b1;
          o_mem_we    = 1'b0;
        end
        StDone: begin
          if (store_q) o_mem_we = 1'b0;
          else         o_mem_wdata = ld_data;
        end
        default: ;
      endcase
    end
  end

  // Bus side is purely register-driven; reset clears it asynchronously.
  assign o_dm_req   = (state_q == StBus);
  assign o_dm_we    = store_q;
  assign o_dm_addr  = addr_q;
  assign o_dm_be    = be_q;
  assign o_dm_wdata = sdata_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_memop;
  logic [31:0] i_addr, i_sdata, i_wdata, i_hi, i_lo, i_dm_rdata;
  logic [4:0]  i_waddr;
  logic        i_we, i_whi, i_wlo, i_dm_ack;
  logic [4:0]  o_mem_waddr;
  logic        o_mem_we, o_mem_whi, o_mem_wlo, o_stall_req, o_dm_req, o_dm_we;
  logic [31:0] o_mem_wdata, o_mem_hi, o_mem_lo, o_dm_addr, o_dm_wdata, o_badaddr;
  logic [3:0]  o_dm_be;
  logic        o_adel, o_ades;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .i_memop(i_memop), .i_addr(i_addr), .i_sdata(i_sdata),
    .i_waddr(i_waddr), .i_we(i_we), .i_wdata(i_wdata),
    .i_whi(i_whi), .i_wlo(i_wlo), .i_hi(i_hi), .i_lo(i_lo),
    .o_mem_waddr(o_mem_waddr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .o_mem_whi(o_mem_whi), .o_mem_wlo(o_mem_wlo), .o_mem_hi(o_mem_hi), .o_mem_lo(o_mem_lo),
    .o_stall_req(o_stall_req), .o_dm_req(o_dm_req), .o_dm_we(o_dm_we),
    .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be), .o_dm_wdata(o_dm_wdata),
    .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
    .o_adel(o_adel), .o_ades(o_ades), .o_badaddr(o_badaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Starts at posedge+1 in IDLE; runs one access and returns in IDLE at posedge+1.
  // ack_at is the index of the BUS cycle in which ack is raised (0 = first).
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int ack_at,
                           output int stalls, output logic [3:0] be, output logic [31:0] dwdata,
                           output logic dwe, output logic [31:0] daddr,
                           output logic [31:0] wb_data, output logic wb_we, output logic req_done);
    int nbus = 0;
    bit done = 0;
    stalls = 0; be = '0; dwdata = '0; dwe = 0; daddr = '0;
    i_memop = op; i_addr = addr; i_sdata = sdata; i_we = 1'b1; i_waddr = 5'd9;
    i_wdata = 32'h5555_5555;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (!o_stall_req) begin done = 1; break; end
      stalls++;
      if (o_dm_req) begin
        be = o_dm_be; dwdata = o_dm_wdata; dwe = o_dm_we; daddr = o_dm_addr;
        i_dm_ack = (nbus == ack_at);
        i_dm_rdata = rdata;
        nbus++;
      end
      @(posedge clk); #1;
      i_dm_ack = 1'b0;
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
    wb_data = o_mem_wdata; wb_we = o_mem_we; req_done = o_dm_req;
    i_memop = 4'd0;
    @(posedge clk); #1;
  endtask

  int          st;
  logic [3:0]  be;
  logic [31:0] dwd, dad, wbd;
  logic        dwe, wbw, rqd;

  initial begin
    rst = 1'b1;
    i_memop = 4'd5; i_addr = 32'h40; i_sdata = 32'h0; i_waddr = 5'd3; i_we = 1'b1;
    i_wdata = 32'h1234; i_whi = 1'b1; i_wlo = 1'b1; i_hi = 32'hDEAD; i_lo = 32'hBEEF;
    i_dm_ack = 1'b0; i_dm_rdata = '0;
    #12;
    check("rst_we", o_mem_we, 0);
    check("rst_wdata", o_mem_wdata, 0);
    check("rst_hi", o_mem_hi, 0);
    check("rst_stall", o_stall_req, 0);
    check("rst_req", o_dm_req, 0);
    i_memop = 0; i_we = 0; i_wdata = 0; i_waddr = 0; i_whi = 0; i_wlo = 0; i_hi = 0; i_lo = 0;
    i_addr = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req", o_dm_req, 0);
    check("post_rst_wdata", o_mem_wdata, 0);

    // Non-memory op passes through combinationally.
    i_we = 1; i_waddr = 5'd3; i_wdata = 32'h1234; i_whi = 1; i_hi = 32'hDEAD;
    #2;
    check("alu_we", o_mem_we, 1);
    check("alu_waddr", o_mem_waddr, 3);
    check("alu_wdata", o_mem_wdata, 32'h1234);
    check("alu_hi", o_mem_hi, 32'hDEAD);
    check("alu_whi", o_mem_whi, 1);
    check("alu_stall", o_stall_req, 0);
    check("alu_req", o_dm_req, 0);
    @(posedge clk); #1;

    // LB, zero-wait ack.
    do_access(4'd1, 32'h1001, 32'h0, 32'h11F2_3344, 0, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("lb_stalls", st, 2);
    check("lb_be", be, 4'b0100);
    check("lb_addr", dad, 32'h1000);
    check("lb_dwe", dwe, 0);
    check("lb_wdata", wbd, 32'hFFFF_FFF2);
    check("lb_we", wbw, 1);
    check("lb_req_done", rqd, 0);

    // LHU, ack in third BUS cycle.
    do_access(4'd4, 32'h2002, 32'h0, 32'hAAAA_8001, 2, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("lhu_stalls", st, 4);
    check("lhu_be", be, 4'b0011);
    check("lhu_wdata", wbd, 32'h0000_8001);

    // LH sign-extend from upper half.
    do_access(4'd3, 32'h0, 32'h0, 32'h8001_1234, 0, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("lh_be", be, 4'b1100);
    check("lh_wdata", wbd, 32'hFFFF_8001);

    // LBU offset 3, LW full word.
    do_access(4'd2, 32'h7, 32'h0, 32'h0102_03F4, 1, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("lbu_be", be, 4'b0001);
    check("lbu_addr", dad, 32'h4);
    check("lbu_wdata", wbd, 32'h0000_00F4);
    do_access(4'd5, 32'h100, 32'h0, 32'h8765_4321, 0, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("lw_be", be, 4'b1111);
    check("lw_wdata", wbd, 32'h8765_4321);

    // Stores.
    do_access(4'd7, 32'h10, 32'hCAFE_BEEF, 32'h0, 0, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("sh_dwe", dwe, 1);
    check("sh_be", be, 4'b1100);
    check("sh_dwdata", dwd, 32'hBEEF_BEEF);
    check("sh_mem_we", wbw, 0);
    do_access(4'd6, 32'h13, 32'h1234_56AB, 32'h0, 0, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("sb_be", be, 4'b0001);
    check("sb_dwdata", dwd, 32'hABAB_ABAB);
    do_access(4'd8, 32'h20, 32'h1357_9BDF, 32'h0, 0, st, be, dwd, dwe, dad, wbd, wbw, rqd);
    check("sw_be", be, 4'b1111);
    check("sw_dwdata", dwd, 32'h1357_9BDF);

    // Misaligned accesses.
    i_memop = 4'd5; i_addr = 32'h3; i_we = 1;
    #2;
    check("lw_mis_adel", o_adel, 1);
    check("lw_mis_ades", o_ades, 0);
    check("lw_mis_bad", o_badaddr, 32'h3);
    check("lw_mis_we", o_mem_we, 0);
    check("lw_mis_stall", o_stall_req, 0);
    @(posedge clk); #1;
    check("lw_mis_req", o_dm_req, 0);
    i_memop = 4'd8; i_addr = 32'h6;
    #2;
    check("sw_mis_ades", o_ades, 1);
    check("sw_mis_adel", o_adel, 0);
    check("sw_mis_bad", o_badaddr, 32'h6);
    i_memop = 4'd3; i_addr = 32'h1;
    #2;
    check("lh_mis_adel", o_adel, 1);
    @(posedge clk); #1;
    check("lh_mis_req", o_dm_req, 0);

    // Reset while in BUS.
    i_memop = 4'd5; i_addr = 32'h40; i_wdata = 32'h55;
    @(posedge clk); #1;
    check("rstbus_req_pre", o_dm_req, 1);
    rst = 1'b1;
    #1;
    check("rstbus_req", o_dm_req, 0);
    check("rstbus_stall", o_stall_req, 0);
    check("rstbus_wdata", o_mem_wdata, 0);
    #2;
    rst = 1'b0;
    i_memop = 0; i_we = 1; i_wdata = 32'h77; i_dm_ack = 1;
    #1;
    check("post_alu_wdata", o_mem_wdata, 32'h77);
    check("post_alu_stall", o_stall_req, 0);
    @(posedge clk); #1;
    i_dm_ack = 0;
    check("late_ack_req", o_dm_req, 0);
    check("late_ack_stall", o_stall_req, 0);
    check("late_ack_wdata", o_mem_wdata, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
